// File: rtl/player_link.sv
// player_link: framed, checksummed player-state transport over one byte-stream UART.
// Periodic TX framer, RX sync hunter with checksum check, byte timeout and link watchdog.
module player_link #(
  parameter int         PAYLOAD_BYTES = 3,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         SEND_PERIOD   = 1_666_667,
  parameter int         BYTE_TIMEOUT  = 20_000,
  parameter int         LINK_TIMEOUT  = 10_000_000,
  localparam int        PW            = 8 * PAYLOAD_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [PW-1:0] local_payload,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_busy,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [PW-1:0] remote_payload,
  output logic          remote_valid,
  output logic          link_up,
  output logic [7:0]    err_cnt
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 2);
  localparam int PER_W = $clog2(SEND_PERIOD + 1);
  localparam int BTO_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int LNK_W = $clog2(LINK_TIMEOUT + 1);

  localparam logic [PER_W-1:0] PER_LAST    = PER_W'(SEND_PERIOD - 1);
  localparam logic [BTO_W-1:0] BTO_RELOAD  = BTO_W'(BYTE_TIMEOUT - 1);
  localparam logic [LNK_W-1:0] LNK_MAX     = LNK_W'(LINK_TIMEOUT);
  localparam logic [LNK_W-1:0] LNK_LAST    = LNK_W'(LINK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] TX_LAST_IDX = IDX_W'(PAYLOAD_BYTES + 1);
  localparam logic [IDX_W-1:0] RX_LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_ACK, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_PAY, RX_CSUM} rx_state_t;

  function automatic logic [7:0] byte_sum(input logic [PW-1:0] p);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) s = s + p[8*i +: 8];
    return s;
  endfunction

  // Free-running period counter
  logic [PER_W-1:0] per_q, per_d;
  logic             send_tick;

  always_comb begin
    send_tick = (per_q == PER_LAST);
    per_d     = send_tick ? '0 : per_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) per_q <= '0;
    else     per_q <= per_d;
  end

  // TX framer: index 0 is sync, 1..N are payload bytes, N+1 is the checksum
  tx_state_t        tx_state_q;
  logic [IDX_W-1:0] tx_idx_q;
  logic [PW-1:0]    tx_shadow_q;
  logic [7:0]       tx_data_q, tx_byte_d;
  logic             tx_start_q;

  always_comb begin
    tx_byte_d = ~byte_sum(tx_shadow_q);
    if (tx_idx_q == '0) tx_byte_d = SYNC_BYTE;
    for (int i = 0; i < PAYLOAD_BYTES; i++)
      if (tx_idx_q == IDX_W'(i + 1)) tx_byte_d = tx_shadow_q[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_idx_q    <= '0;
      tx_shadow_q <= '0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_tick) begin
            tx_shadow_q <= local_payload;
            tx_idx_q    <= '0;
            tx_state_q  <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (!tx_busy) begin
            tx_data_q  <= tx_byte_d;
            tx_start_q <= 1'b1;
            tx_state_q <= TX_ACK;
          end
        end
        TX_ACK: begin
          if (tx_busy) tx_state_q <= TX_DONE;
        end
        TX_DONE: begin
          if (!tx_busy) begin
            if (tx_idx_q == TX_LAST_IDX) begin
              tx_state_q <= TX_IDLE;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              tx_state_q <= TX_SEND;
            end
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  // RX deframer with byte timeout, error counter and link watchdog
  rx_state_t        rx_state_q;
  logic [IDX_W-1:0] rx_idx_q;
  logic [7:0]       rx_sum_q;
  logic [PW-1:0]    rx_shadow_q;
  logic [BTO_W-1:0] bto_q;
  logic [PW-1:0]    remote_q;
  logic             remote_valid_q;
  logic [LNK_W-1:0] link_cnt_q;
  logic             link_up_q;
  logic [7:0]       err_q;
  logic             rx_good, rx_bad, rx_timeout;

  always_comb begin
    rx_timeout = (rx_state_q != RX_HUNT) && !rx_valid && (bto_q == '0);
    rx_good    = (rx_state_q == RX_CSUM) && rx_valid && (rx_data == ~rx_sum_q);
    rx_bad     = (rx_state_q == RX_CSUM) && rx_valid && (rx_data != ~rx_sum_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q     <= RX_HUNT;
      rx_idx_q       <= '0;
      rx_sum_q       <= '0;
      rx_shadow_q    <= '0;
      bto_q          <= '0;
      remote_q       <= '0;
      remote_valid_q <= 1'b0;
      link_cnt_q     <= '0;
      link_up_q      <= 1'b0;
      err_q          <= '0;
    end else begin
      remote_valid_q <= 1'b0;
      if ((rx_bad || rx_timeout) && err_q != 8'hFF) err_q <= err_q + 8'd1;

      if (rx_good) begin
        remote_q       <= rx_shadow_q;
        remote_valid_q <= 1'b1;
        link_cnt_q     <= '0;
        link_up_q      <= 1'b1;
      end else if (link_cnt_q != LNK_MAX) begin
        link_cnt_q <= link_cnt_q + 1'b1;
        if (link_cnt_q == LNK_LAST) link_up_q <= 1'b0;
      end

      case (rx_state_q)
        RX_HUNT: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            rx_idx_q   <= '0;
            rx_sum_q   <= '0;
            bto_q      <= BTO_RELOAD;
            rx_state_q <= RX_PAY;
          end
        end
        RX_PAY: begin
          if (rx_valid) begin
            for (int i = 0; i < PAYLOAD_BYTES; i++)
              if (rx_idx_q == IDX_W'(i)) rx_shadow_q[8*i +: 8] <= rx_data;
            rx_sum_q <= rx_sum_q + rx_data;
            bto_q    <= BTO_RELOAD;
            if (rx_idx_q == RX_LAST_IDX) rx_state_q <= RX_CSUM;
            else                         rx_idx_q   <= rx_idx_q + 1'b1;
          end else if (rx_timeout) begin
            rx_state_q <= RX_HUNT;
          end else begin
            bto_q <= bto_q - 1'b1;
          end
        end
        RX_CSUM: begin
          if (rx_valid || rx_timeout) rx_state_q <= RX_HUNT;
          else                        bto_q      <= bto_q - 1'b1;
        end
        default: rx_state_q <= RX_HUNT;
      endcase
    end
  end

  assign tx_data        = tx_data_q;
  assign tx_start       = tx_start_q;
  assign remote_payload = remote_q;
  assign remote_valid   = remote_valid_q;
  assign link_up        = link_up_q;
  assign err_cnt        = err_q;

endmodule

// File: tb/tb_player_link.sv
// Scoreboard bench for player_link: UART busy model, TX/RX expected queues fed by stimulus,
// and a negedge monitor that pops and compares whenever the DUT presents a byte or payload.
module tb_player_link;
  localparam int PB = 3;
  localparam int PW = 8 * PB;
  localparam int SP = 100;
  localparam int BT = 200;
  localparam int LT = 3000;
  localparam logic [7:0] SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] local_payload;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_busy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [PW-1:0] remote_payload;
  logic          remote_valid;
  logic          link_up;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  player_link #(
    .PAYLOAD_BYTES(PB), .SYNC_BYTE(SYNC), .SEND_PERIOD(SP),
    .BYTE_TIMEOUT(BT), .LINK_TIMEOUT(LT)
  ) dut (
    .clk(clk), .rst(rst), .local_payload(local_payload),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .remote_payload(remote_payload), .remote_valid(remote_valid),
    .link_up(link_up), .err_cnt(err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // Reference model: frame layout and checksum from plain arithmetic
  function automatic logic [7:0] ref_csum(input logic [PW-1:0] p);
    int s;
    logic [7:0] r;
    s = 0;
    for (int i = 0; i < PB; i++) s += int'(p[8*i +: 8]);
    r = 8'(s);
    return ~r;
  endfunction

  logic [7:0]    tx_exp_q[$];
  logic [PW-1:0] rx_exp_q[$];
  int            exp_err = 0;

  task automatic push_tx_frame(input logic [PW-1:0] p);
    tx_exp_q.push_back(SYNC);
    for (int i = 0; i < PB; i++) tx_exp_q.push_back(p[8*i +: 8]);
    tx_exp_q.push_back(ref_csum(p));
  endtask

  function automatic int sat_inc(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  // UART busy model and output monitor
  int cyc = 0;
  int busy_cnt = 0;
  int tx_nstart = 0;
  int tx_mid_cnt = 0;
  int last_sync_cyc = 0;
  int link_run = 0;
  int link_falls = 0;
  bit prev_tx_start = 1'b0;
  bit prev_rv = 1'b0;
  bit prev_link = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cyc = 0; busy_cnt = 0; tx_busy = 1'b0; tx_nstart = 0;
      prev_tx_start = 1'b0; prev_rv = 1'b0; prev_link = 1'b0; link_run = 0;
    end else begin
      if (tx_start) begin
        check("tx_start_single_cycle", 32'(prev_tx_start), 0);
        if (tx_exp_q.size() == 0) note_fail("tx_unexpected_byte");
        else check("tx_byte", tx_data, tx_exp_q.pop_front());
        if (tx_nstart % 5 == 0) begin
          if (tx_nstart == 0) check("tx_first_start_after_reset", 32'(cyc >= SP && cyc <= SP + 2), 1);
          else                check("tx_frame_spacing", cyc - last_sync_cyc, SP);
          last_sync_cyc = cyc;
        end
        if (tx_nstart % 5 == 1) tx_mid_cnt++;
        tx_nstart++;
        busy_cnt = 10;
        tx_busy  = 1'b1;
      end else begin
        if (busy_cnt > 0) busy_cnt--;
        tx_busy = (busy_cnt != 0);
      end
      prev_tx_start = tx_start;

      if (remote_valid) begin
        check("remote_valid_single_cycle", 32'(prev_rv), 0);
        if (rx_exp_q.size() == 0) note_fail("rx_unexpected_remote_valid");
        else check("remote_payload", remote_payload, rx_exp_q.pop_front());
        check("link_up_on_good_frame", 32'(link_up), 1);
        link_run = 0;
      end
      prev_rv = remote_valid;
      if (link_up) link_run++;
      if (prev_link && !link_up) begin
        check("link_up_fall_count", link_run, LT);
        link_falls++;
      end
      prev_link = link_up;
    end
  end

  // TX stimulus: change local_payload mid-frame; the change belongs to the next frame
  bit tx_rand_en = 1'b1;
  initial begin
    int seen;
    logic [PW-1:0] p;
    seen = 0;
    local_payload = 24'h123456;
    push_tx_frame(24'h123456);
    forever begin
      @(negedge clk);
      #1;
      if (tx_mid_cnt != seen) begin
        seen = tx_mid_cnt;
        if (tx_rand_en) begin
          p = PW'($urandom);
          local_payload = p;
          push_tx_frame(p);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [PW-1:0] p, input logic [7:0] cs, input int max_gap);
    send_byte(SYNC, $urandom_range(0, max_gap));
    for (int i = 0; i < PB; i++) send_byte(p[8*i +: 8], $urandom_range(0, max_gap));
    send_byte(cs, 0);
  endtask

  task automatic settle_and_check_err(input string name);
    repeat (3) @(negedge clk);
    check(name, err_cnt, exp_err);
  endtask

  initial begin
    logic [PW-1:0] p, last_good;
    logic [7:0]    cs, nb;
    bit            bad;
    int            k, seen, falls0;

    #1 rst = 1'b1;
    #2;
    check("reset_tx_start", 32'(tx_start), 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_remote_payload", remote_payload, 0);
    check("reset_remote_valid", 32'(remote_valid), 0);
    check("reset_link_up", 32'(link_up), 0);
    check("reset_err_cnt", err_cnt, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // Good frame 123456 / 63
    rx_exp_q.push_back(24'h123456);
    send_frame(24'h123456, 8'h63, 2);
    settle_and_check_err("err_after_good");
    check("link_up_after_good", 32'(link_up), 1);

    // Bad checksum 64
    exp_err = sat_inc(exp_err);
    send_frame(24'h123456 ^ 24'h0, 8'h64, 2);
    settle_and_check_err("err_after_bad_csum");
    check("remote_held_after_bad", remote_payload, 24'h123456);

    // Noise then a payload containing the sync value
    send_byte(8'h00, 1); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'hB6, 0);
    exp_err = sat_inc(exp_err);
    settle_and_check_err("err_after_sync_in_payload_bad");
    rx_exp_q.push_back(24'h00A5A5);
    send_byte(8'h00, 1); send_byte(8'hA5, 0); send_byte(8'hA5, 0);
    send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'hB5, 0);
    settle_and_check_err("err_after_sync_in_payload_good");

    // Byte timeout mid-frame
    send_byte(SYNC, 0);
    send_byte(8'h56, 0);
    repeat (BT - 10) @(negedge clk);
    check("err_before_byte_timeout", err_cnt, exp_err);
    repeat (20) @(negedge clk);
    exp_err = sat_inc(exp_err);
    check("err_after_byte_timeout", err_cnt, exp_err);
    p = PW'($urandom);
    rx_exp_q.push_back(p);
    send_frame(p, ref_csum(p), 3);
    settle_and_check_err("err_after_recovery_frame");

    // Randomized frames with noise, gaps and corrupted checksums
    for (int f = 0; f < 40; f++) begin
      for (int n = $urandom_range(0, 2); n > 0; n--) begin
        nb = 8'($urandom);
        if (nb == SYNC) nb = 8'h5A;
        send_byte(nb, $urandom_range(0, 3));
      end
      p   = PW'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      cs  = ref_csum(p);
      if (bad) begin
        cs = cs ^ 8'($urandom_range(1, 255));
        exp_err = sat_inc(exp_err);
      end else begin
        rx_exp_q.push_back(p);
      end
      send_frame(p, cs, 5);
      settle_and_check_err("err_random_frame");
    end

    // Link watchdog
    last_good = PW'($urandom);
    rx_exp_q.push_back(last_good);
    send_frame(last_good, ref_csum(last_good), 1);
    falls0 = link_falls;
    repeat (LT + 20) @(negedge clk);
    check("link_down_after_timeout", 32'(link_up), 0);
    check("link_fall_seen", link_falls - falls0, 1);
    check("remote_held_after_link_down", remote_payload, last_good);

    // err_cnt saturation
    for (int f = 0; f < 300; f++) begin
      p = PW'($urandom);
      send_frame(p, ref_csum(p) ^ 8'hFF, 0);
      exp_err = sat_inc(exp_err);
    end
    settle_and_check_err("err_saturated");
    check("remote_held_after_bad_burst", remote_payload, last_good);
    check("rx_scoreboard_drained", rx_exp_q.size(), 0);

    // Reset during a TX payload byte
    tx_rand_en = 1'b0;
    seen = tx_mid_cnt;
    k = 0;
    while (tx_mid_cnt == seen && k < 3 * SP) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("tx_payload_byte_reached", 32'(tx_mid_cnt != seen), 1);
    check("tx_start_before_reset", 32'(tx_start), 1);
    #1 rst = 1'b1;
    #1;
    check("midframe_reset_tx_start", 32'(tx_start), 0);
    check("midframe_reset_tx_data", tx_data, 0);
    check("midframe_reset_remote_payload", remote_payload, 0);
    check("midframe_reset_link_up", 32'(link_up), 0);
    check("midframe_reset_err_cnt", err_cnt, 0);
    tx_exp_q.delete();
    push_tx_frame(local_payload);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    k = 0;
    while (tx_nstart < 5 && k < 2 * SP + 50) begin
      @(negedge clk);
      k++;
    end
    check("tx_frame_after_reset_complete", 32'(tx_nstart >= 5), 1);
    check("tx_scoreboard_drained", tx_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
